// File: rtl/ppg_pkg.sv
// Shared defaults and state encodings for the PPG window statistics block.
// Contents: default DATA_W / WIN_LOG2, collection FSM states, beat detector states.
package ppg_pkg;

    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_WIN_LOG2 = 7;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } ppg_state_t;

    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } beat_state_t;

endpackage

// File: rtl/ppg_channel_acc.sv
// Per-channel window accumulator: running max, min, sum and sample count.
// Ports:
//   CLK, rst_n    clock, async active-low reset
//   clear         return stats to empty (max=0, min=all-ones, sum=0, cnt=0)
//   upd           sample strobe for this channel; ignored once the window is full
//   sample        ADC value
//   full          count has reached 2^WIN_LOG2 (registered)
//   *_nxt_c       combinational post-update stats, used by the top at window end
module ppg_channel_acc
    import ppg_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned WIN_LOG2 = DEF_WIN_LOG2
) (
    input  logic                       CLK,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       upd,
    input  logic [DATA_W-1:0]          sample,
    output logic                       full,
    output logic [DATA_W-1:0]          max_nxt_c,
    output logic [DATA_W-1:0]          min_nxt_c,
    output logic [DATA_W+WIN_LOG2-1:0] sum_nxt_c,
    output logic                       full_nxt_c
);

    localparam int unsigned SUM_W = DATA_W + WIN_LOG2;
    localparam int unsigned CNT_W = WIN_LOG2 + 1;

    logic [DATA_W-1:0] max_q;
    logic [DATA_W-1:0] min_q;
    logic [SUM_W-1:0]  sum_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_nxt_c;
    logic              take_c;

    assign full = cnt_q[WIN_LOG2];

    // Post-update stats; a sample for a full channel leaves them untouched
    always_comb begin
        take_c     = upd && !full;
        max_nxt_c  = max_q;
        min_nxt_c  = min_q;
        sum_nxt_c  = sum_q;
        cnt_nxt_c  = cnt_q;
        if (take_c) begin
            if (sample > max_q) max_nxt_c = sample;
            if (sample < min_q) min_nxt_c = sample;
            sum_nxt_c = sum_q + SUM_W'(sample);
            cnt_nxt_c = cnt_q + CNT_W'(1);
        end
        full_nxt_c = cnt_nxt_c[WIN_LOG2];
    end

    // Stats registers; clear wins over update
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
            min_q <= '1;
            sum_q <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            max_q <= '0;
            min_q <= '1;
            sum_q <= '0;
            cnt_q <= '0;
        end else begin
            max_q <= max_nxt_c;
            min_q <= min_nxt_c;
            sum_q <= sum_nxt_c;
            cnt_q <= cnt_nxt_c;
        end
    end

endmodule

// File: rtl/ppg_window_stats.sv
// Windowed RED/IR statistics: per-window AC (max-min) and DC (mean) for both
// channels, published through a valid/ready result register with sticky overrun.
// Optional IR beat detector enabled by macro PPG_BEAT_DETECT_EN.
// Ports:
//   CLK, rst_n                      clock, async active-low reset
//   settings_done                   calibration complete; low aborts the window
//   sample_valid/sample_is_red/sample  time-multiplexed ADC samples
//   result_ready / result_valid     result handshake
//   red_ac, red_dc, ir_ac, ir_dc    published window results
//   overrun                         sticky: window completed while a result was pending
//   beat_pulse, beat_period         IR beat strobe and period in IR samples (macro only, else 0)
module ppg_window_stats
    import ppg_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned WIN_LOG2 = DEF_WIN_LOG2,
    parameter int unsigned HYST     = 4,
    parameter int unsigned PERIOD_W = 12
) (
    input  logic                CLK,
    input  logic                rst_n,
    input  logic                settings_done,
    input  logic                sample_valid,
    input  logic                sample_is_red,
    input  logic [DATA_W-1:0]   sample,
    input  logic                result_ready,
    output logic                result_valid,
    output logic [DATA_W-1:0]   red_ac,
    output logic [DATA_W-1:0]   red_dc,
    output logic [DATA_W-1:0]   ir_ac,
    output logic [DATA_W-1:0]   ir_dc,
    output logic                overrun,
    output logic                beat_pulse,
    output logic [PERIOD_W-1:0] beat_period
);

    localparam int unsigned SUM_W = DATA_W + WIN_LOG2;

    // Hysteresis must be representable in the sample width
    if (HYST >= (32'd1 << DATA_W)) begin : g_bad_hyst
        $error("HYST does not fit in DATA_W bits");
    end

    ppg_state_t        state_q;
    ppg_state_t        state_nxt;
    logic              collect_c;
    logic              abort_c;
    logic              red_upd_c;
    logic              ir_upd_c;
    logic              win_end_c;
    logic              clear_c;
    logic              load_c;

    logic              red_full, ir_full;
    logic              red_full_nxt_c, ir_full_nxt_c;
    logic [DATA_W-1:0] red_max_nxt_c, red_min_nxt_c, ir_max_nxt_c, ir_min_nxt_c;
    logic [SUM_W-1:0]  red_sum_nxt_c, ir_sum_nxt_c;

    // Collection FSM: state register
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    // Collection FSM: next state
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (settings_done)  state_nxt = COLLECT;
            COLLECT: if (!settings_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Collection FSM: control outputs
    always_comb begin
        collect_c = (state_q == COLLECT) && settings_done;
        abort_c   = (state_q == COLLECT) && !settings_done;
        red_upd_c = collect_c && sample_valid && sample_is_red  && !red_full;
        ir_upd_c  = collect_c && sample_valid && !sample_is_red && !ir_full;
        // The accepted sample that leaves both channels full closes the window
        win_end_c = (red_upd_c || ir_upd_c) && red_full_nxt_c && ir_full_nxt_c;
        clear_c   = abort_c || win_end_c;
        load_c    = win_end_c && (!result_valid || result_ready);
    end

    ppg_channel_acc #(.DATA_W(DATA_W), .WIN_LOG2(WIN_LOG2)) u_red_acc (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .clear      (clear_c),
        .upd        (red_upd_c),
        .sample     (sample),
        .full       (red_full),
        .max_nxt_c  (red_max_nxt_c),
        .min_nxt_c  (red_min_nxt_c),
        .sum_nxt_c  (red_sum_nxt_c),
        .full_nxt_c (red_full_nxt_c)
    );

    ppg_channel_acc #(.DATA_W(DATA_W), .WIN_LOG2(WIN_LOG2)) u_ir_acc (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .clear      (clear_c),
        .upd        (ir_upd_c),
        .sample     (sample),
        .full       (ir_full),
        .max_nxt_c  (ir_max_nxt_c),
        .min_nxt_c  (ir_min_nxt_c),
        .sum_nxt_c  (ir_sum_nxt_c),
        .full_nxt_c (ir_full_nxt_c)
    );

    // Result registers and handshake; a pending unaccepted result is never overwritten
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            result_valid <= 1'b0;
            red_ac       <= '0;
            red_dc       <= '0;
            ir_ac        <= '0;
            ir_dc        <= '0;
            overrun      <= 1'b0;
        end else begin
            if (load_c) begin
                result_valid <= 1'b1;
                red_ac       <= red_max_nxt_c - red_min_nxt_c;
                red_dc       <= DATA_W'(red_sum_nxt_c >> WIN_LOG2);
                ir_ac        <= ir_max_nxt_c - ir_min_nxt_c;
                ir_dc        <= DATA_W'(ir_sum_nxt_c >> WIN_LOG2);
            end else if (result_ready) begin
                result_valid <= 1'b0;
            end
            if (win_end_c && result_valid && !result_ready) overrun <= 1'b1;
        end
    end

`ifdef PPG_BEAT_DETECT_EN
    localparam int unsigned THR_W = DATA_W + 1;

    beat_state_t         bstate_q;
    beat_state_t         bstate_nxt;
    logic                thr_valid_q;
    logic                have_beat_q;
    logic [PERIOD_W-1:0] per_cnt_q;
    logic [THR_W-1:0]    hi_sum_c;
    logic [DATA_W-1:0]   thr_hi_c;
    logic [DATA_W-1:0]   thr_lo_c;
    logic                ir_evt_c;
    logic                rise_c;
    logic                cnt_sat_c;
    logic [PERIOD_W-1:0] cnt_inc_c;

    // Hysteresis band around the last published IR DC, clamped to the sample range
    always_comb begin
        hi_sum_c = {1'b0, ir_dc} + THR_W'(HYST);
        thr_hi_c = hi_sum_c[DATA_W] ? '1 : hi_sum_c[DATA_W-1:0];
        thr_lo_c = (ir_dc > DATA_W'(HYST)) ? (ir_dc - DATA_W'(HYST)) : '0;
        ir_evt_c = collect_c && sample_valid && !sample_is_red && thr_valid_q;
    end

    // Beat FSM: state register
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) bstate_q <= LOW;
        else        bstate_q <= bstate_nxt;
    end

    // Beat FSM: next state
    always_comb begin
        bstate_nxt = bstate_q;
        if (ir_evt_c) begin
            case (bstate_q)
                LOW:     if (sample > thr_hi_c) bstate_nxt = HIGH;
                HIGH:    if (sample < thr_lo_c) bstate_nxt = LOW;
                default: bstate_nxt = LOW;
            endcase
        end
    end

    // Beat FSM: outputs; the reported period counts the rising sample itself
    always_comb begin
        rise_c    = ir_evt_c && (bstate_q == LOW) && (bstate_nxt == HIGH);
        cnt_sat_c = &per_cnt_q;
        cnt_inc_c = cnt_sat_c ? per_cnt_q : per_cnt_q + PERIOD_W'(1);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            thr_valid_q <= 1'b0;
            have_beat_q <= 1'b0;
            per_cnt_q   <= '0;
            beat_pulse  <= 1'b0;
            beat_period <= '0;
        end else begin
            if (load_c) thr_valid_q <= 1'b1;
            beat_pulse <= rise_c;
            if (rise_c) begin
                per_cnt_q   <= '0;
                have_beat_q <= 1'b1;
                if (have_beat_q && !cnt_sat_c) beat_period <= cnt_inc_c;
            end else if (ir_evt_c) begin
                per_cnt_q <= cnt_inc_c;
            end
        end
    end
`else
    assign beat_pulse  = 1'b0;
    assign beat_period = '0;
`endif

endmodule
